// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: one quotient bit per clock, start/done handshake.
// Optional macro DIV_POW2_SHORTCUT_EN resolves power-of-two divisors in a single cycle.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shift_q;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] part;       // partial remainder, always < dvs between steps
    logic [CW-1:0]    cnt;

    logic [WIDTH:0]   part_shift;
    logic [WIDTH-1:0] part_next;
    logic             q_bit;
    logic             last_iter;
    logic             is_pow2;
    logic [WIDTH-1:0] pow2_q;

    // One restoring step: the trial subtraction needs WIDTH+1 bits, its result fits in WIDTH.
    always_comb begin
        part_shift = {part, shift_q[WIDTH-1]};
        q_bit      = (part_shift >= {1'b0, dvs});
        part_next  = q_bit ? WIDTH'(part_shift - {1'b0, dvs}) : part_shift[WIDTH-1:0];
    end

    assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef DIV_POW2_SHORTCUT_EN
    always_comb begin
        is_pow2 = (divisor != '0) && ((divisor & (divisor - WIDTH'(1))) == '0);
        pow2_q  = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (divisor[k]) pow2_q = dividend >> k;
        end
    end
`else
    assign is_pow2 = 1'b0;
    assign pow2_q  = '0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = ((divisor == '0) || is_pow2) ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // NOTE: working registers are reset too, so an aborted division leaves nothing stale behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            dvs         <= '0;
            part        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else if (is_pow2) begin
                            quotient    <= pow2_q;
                            remainder   <= dividend & (divisor - WIDTH'(1));
                            div_by_zero <= 1'b0;
                        end else begin
                            shift_q <= dividend;
                            dvs     <= divisor;
                            part    <= '0;
                            cnt     <= '0;
                        end
                    end
                end
                RUN: begin
                    shift_q <= {shift_q[WIDTH-2:0], q_bit};
                    part    <= part_next;
                    cnt     <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient    <= {shift_q[WIDTH-2:0], q_bit};
                        remainder   <= part_next;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8): directed boundaries, random ops vs. an
// arithmetic reference model, ignored starts, and reset abort.
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic; latency is the negedge index (after the start edge) where done shows.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r,
                           output logic dz, output int lat, output int busy_cycles);
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1; lat = 1;
        end else begin
            q = a / b; r = a % b; dz = 1'b0; lat = W + 1;
`ifdef DIV_POW2_SHORTCUT_EN
            if ($countones(b) == 1) lat = 1;
`endif
        end
        busy_cycles = (lat == 1) ? 0 : W;
    endtask

    // Drive one start pulse and observe the result; operands are scrambled after the start edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                          output int done_cyc, output int busy_cnt, output logic single);
        q = 'x; r = 'x; dz = 1'bx; done_cyc = -1; busy_cnt = 0;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            dividend = W'($urandom);
            divisor = W'($urandom);
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = c; q = quotient; r = remainder; dz = div_by_zero;
                break;
            end
        end
        @(negedge clk);
        single = !done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_during: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_after: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] tbl_a [12] = '{100, 200, 37, 9, 5, 255, 0, 123, 255, 1, 128, 254};
        logic [W-1:0] tbl_b [12] = '{7, 4, 0, 3, 9, 255, 13, 1, 1, 255, 128, 255};
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, single;
        int dc, bc, elat, ebc;
        for (int i = 0; i < 12; i++) begin
            ref_div(tbl_a[i], tbl_b[i], eq, er, edz, elat, ebc);
            run_op(tbl_a[i], tbl_b[i], q, r, dz, dc, bc, single);
            checks++;
            if (q !== eq || r !== er || dz !== edz) begin
                errors++;
                $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         tbl_a[i], tbl_b[i], q, r, dz, eq, er, edz);
            end
            checks++;
            if (dc !== elat || bc !== ebc || single !== 1'b1) begin
                errors++;
                $display("FAIL directed_timing %0d/%0d: got done_cycle=%0d busy_cycles=%0d single=%b expected %0d %0d 1",
                         tbl_a[i], tbl_b[i], dc, bc, single, elat, ebc);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic dz, edz, single;
        int dc, bc, elat, ebc, sel;
        for (int i = 0; i < 1500; i++) begin
            sel = int'($urandom_range(0, 7));
            a = (sel == 1) ? '1 : W'($urandom);
            if (sel == 0)      b = '0;
            else if (sel == 2) b = W'(1) << $urandom_range(0, W - 1);
            else               b = W'($urandom);
            ref_div(a, b, eq, er, edz, elat, ebc);
            run_op(a, b, q, r, dz, dc, bc, single);
            checks++;
            if (q !== eq || r !== er || dz !== edz) begin
                errors++;
                $display("FAIL random_result %0d/%0d: got q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                         a, b, q, r, dz, eq, er, edz);
            end
            checks++;
            if (dc !== elat || bc !== ebc || single !== 1'b1) begin
                errors++;
                $display("FAIL random_timing %0d/%0d: got done_cycle=%0d busy_cycles=%0d single=%b expected %0d %0d 1",
                         a, b, dc, bc, single, elat, ebc);
            end
            if (b != 0) begin
                checks++;
                if (!(r < b)) begin
                    errors++;
                    $display("FAIL random_rem_bound %0d/%0d: remainder %0d not below divisor", a, b, r);
                end
            end
        end
    endtask

    task automatic test_ignore_during_run();
        int pulses = 0;
        int first = -1;
        @(negedge clk);
        dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 3 || c == 4) begin
                start = 1'b1; dividend = 50; divisor = 5;
            end else begin
                start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
            end
            if (done) begin
                pulses++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (pulses !== 1 || first !== W + 1) begin
            errors++;
            $display("FAIL ignore_run_done: got %0d pulses first at %0d expected 1 at %0d", pulses, first, W + 1);
        end
        checks++;
        if (quotient !== 8'd14 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL ignore_run_result: got q=%0d r=%0d dz=%b expected q=14 r=2 dz=0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_in_done();
        int seen = 0;
        logic hit = 1'b0;
        @(negedge clk);
        dividend = 200; divisor = 3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (done) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL done_start_wait: got no done within 30 cycles expected a done pulse");
        end
        start = 1'b1; dividend = 7; divisor = 2;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (busy || done) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0 || quotient !== 8'd66 || remainder !== 8'd2 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: got activity=%0d q=%0d r=%0d dz=%b expected 0 q=66 r=2 dz=0",
                     seen, quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] q, r;
        logic dz, single;
        int dc, bc, late = 0;
        @(negedge clk);
        dividend = 100; divisor = 7; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
            errors++;
            $display("FAIL reset_abort: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) late++;
        end
        checks++;
        if (late !== 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles after release expected 0", late);
        end
        run_op(81, 9, q, r, dz, dc, bc, single);
        checks++;
        if (q !== 8'd9 || r !== 8'd0 || dz !== 1'b0 || dc !== W + 1) begin
            errors++;
            $display("FAIL reset_fresh_op: got q=%0d r=%0d dz=%b done_cycle=%0d expected q=9 r=0 dz=0 %0d",
                     q, r, dz, dc, W + 1);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_during_run();
        test_start_in_done();
        test_random();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
